// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one FIFO write port between
// NUM_REQ requesters. Each write walks IDLE -> ISSUE -> ACK -> DONE; a
// missing ack or an overflow sends the FSM back to IDLE with the pointer
// unchanged so the same requester is reissued.
// Optional feature: define FIFO_WR_ARB_RETRY_CNT_EN to add the saturating
// 8-bit retry_cnt output that counts ACK-to-IDLE retries.
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          arb_busy
`ifdef FIFO_WR_ARB_RETRY_CNT_EN
    ,
    output logic [7:0]                    retry_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0]   ONE_IDX  = IDX_W'(1);
    localparam logic [NUM_REQ-1:0] GNT_LSB  = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        winner;
    logic [IDX_W-1:0]        rr_idx;
    logic                    rr_found;
    logic                    write_ok;
    logic [IDX_W-1:0]        ptr_next;
    logic [FIFO_WIDTH-1:0]   data_arr [NUM_REQ];

    // Unpack the flat requester data bus into one word per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // A write only counts as done when acked and not flagged as overflow.
    assign write_ok = fifo_wr_ack && !fifo_overflow;

    // Pointer moves to the requester just after the winner, wrapping.
    assign ptr_next = (winner == LAST_IDX) ? '0 : winner + ONE_IDX;

    // Round-robin search: scan offsets from the far end toward ptr so the
    // lowest offset from ptr that is requesting overwrites the others.
    always_comb begin : rr_search
        int cand;
        // NOTE: every variable assigned here gets a default first so no
        // path leaves it unassigned and no latch is inferred.
        cand     = 0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[cand[IDX_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Arbitration FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            winner       <= '0;
            gnt          <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            arb_busy     <= 1'b0;
        end else begin
            gnt        <= '0;
            fifo_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (rr_found && !fifo_full) begin
                        winner       <= rr_idx;
                        fifo_data_in <= data_arr[rr_idx];
                        fifo_wr_en   <= 1'b1;
                        arb_busy     <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= ACK;
                end
                ACK: begin
                    if (write_ok) begin
                        gnt   <= GNT_LSB << winner;
                        state <= DONE;
                    end else begin
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DONE: begin
                    ptr      <= ptr_next;
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_RETRY_CNT_EN
    // Count failed writes (ACK without a clean ack), saturating at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (state == ACK && !write_ok && retry_cnt != 8'hFF) begin
            retry_cnt <= retry_cnt + 8'd1;
        end
    end
`endif

    // Grants are one-hot or idle by construction.
    a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: reset state, single requester, round-robin
// order, full blocking, overflow retry, request/data changes after latching,
// reset mid-transaction and pointer-based priority.
module tb_fifo_wr_arb;

    localparam int NUM_REQ    = 4;
    localparam int FIFO_WIDTH = 16;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic                          arb_busy;
`ifdef FIFO_WR_ARB_RETRY_CNT_EN
    logic [7:0]                    retry_cnt;
`endif

    int n_vec;
    int n_bad;

    fifo_wr_arb #(
        .NUM_REQ    (NUM_REQ),
        .FIFO_WIDTH (FIFO_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_data_in  (fifo_data_in),
        .fifo_full     (fifo_full),
        .fifo_wr_ack   (fifo_wr_ack),
        .fifo_overflow (fifo_overflow),
        .arb_busy      (arb_busy)
`ifdef FIFO_WR_ARB_RETRY_CNT_EN
        ,
        .retry_cnt     (retry_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: ack/overflow are registered responses to fifo_wr_en.
    always @(posedge clk) begin
        fifo_wr_ack   <= fifo_wr_en && !fifo_full;
        fifo_overflow <= fifo_wr_en && fifo_full;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [FIFO_WIDTH-1:0] val);
        req_data[idx*FIFO_WIDTH +: FIFO_WIDTH] = val;
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_gnt",  32'(gnt), 32'h0);
        check("rst_wren", 32'(fifo_wr_en), 32'h0);
        check("rst_data", 32'(fifo_data_in), 32'h0);
        check("rst_busy", 32'(arb_busy), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 16'h1000 + 16'(i));

        // Single requester 1 with A5A5
        set_data(1, 16'hA5A5);
        req = 4'b0010;
        tick();
        check("single_wren", 32'(fifo_wr_en), 32'h1);
        check("single_data", 32'(fifo_data_in), 32'hA5A5);
        check("single_busy", 32'(arb_busy), 32'h1);
        check("single_gnt_early", 32'(gnt), 32'h0);
        tick();
        check("single_ack_wren", 32'(fifo_wr_en), 32'h0);
        check("single_ack_gnt", 32'(gnt), 32'h0);
        tick();
        check("single_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        check("single_idle_gnt", 32'(gnt), 32'h0);
        check("single_idle_busy", 32'(arb_busy), 32'h0);
        set_data(1, 16'h1001);

        // All requesters held: grants 0,1,2,3,0 every 4 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr_wren", 32'(fifo_wr_en), 32'h1);
            check("rr_data", 32'(fifo_data_in), 32'h1000 + 32'(g % 4));
            tick();
            check("rr_ack_wren", 32'(fifo_wr_en), 32'h0);
            tick();
            check("rr_gnt", 32'(gnt), 32'(1) << (g % 4));
            tick();
            check("rr_idle_gnt", 32'(gnt), 32'h0);
            check("rr_idle_busy", 32'(arb_busy), 32'h0);
        end
        req = '0;

        // ptr=1 with req 1001: requester 3 before requester 0
        req = 4'b1001;
        tick();
        check("ptr_first_data", 32'(fifo_data_in), 32'h1003);
        tick();
        tick();
        check("ptr_first_gnt", 32'(gnt), 32'h8);
        req = 4'b0001;
        tick();
        tick();
        check("ptr_second_data", 32'(fifo_data_in), 32'h1000);
        tick();
        tick();
        check("ptr_second_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();

        // FIFO full blocks issue; write goes out the cycle after it drops
        fifo_full = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_wren", 32'(fifo_wr_en), 32'h0);
            check("full_busy", 32'(arb_busy), 32'h0);
        end
        fifo_full = 1'b0;
        tick();
        check("unfull_wren", 32'(fifo_wr_en), 32'h1);
        check("unfull_data", 32'(fifo_data_in), 32'h1000);
        tick();
        tick();
        check("unfull_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();

        // Full rises during ISSUE -> overflow in ACK -> retry same requester
        req = 4'b0100;
        tick();
        check("ovf_wren", 32'(fifo_wr_en), 32'h1);
        check("ovf_data", 32'(fifo_data_in), 32'h1002);
        fifo_full = 1'b1;
        tick();
        check("ovf_ack_busy", 32'(arb_busy), 32'h1);
        check("ovf_ack_wren", 32'(fifo_wr_en), 32'h0);
        fifo_full = 1'b0;
        tick();
        check("ovf_no_gnt", 32'(gnt), 32'h0);
        check("ovf_retry_idle", 32'(arb_busy), 32'h0);
        tick();
        check("retry_wren", 32'(fifo_wr_en), 32'h1);
        check("retry_data", 32'(fifo_data_in), 32'h1002);
        tick();
        tick();
        check("retry_gnt", 32'(gnt), 32'h4);
        req = '0;
        tick();
`ifdef FIFO_WR_ARB_RETRY_CNT_EN
        check("retry_cnt", 32'(retry_cnt), 32'h1);
`endif

        // req dropped and data changed after latching: write and gnt stand
        req = 4'b0001;
        tick();
        check("hold_data_issue", 32'(fifo_data_in), 32'h1000);
        req = '0;
        set_data(0, 16'hDEAD);
        tick();
        check("hold_data_ack", 32'(fifo_data_in), 32'h1000);
        tick();
        check("hold_gnt", 32'(gnt), 32'h1);
        tick();
        check("hold_data_idle", 32'(fifo_data_in), 32'h1000);
        check("hold_idle_gnt", 32'(gnt), 32'h0);
        set_data(0, 16'h1000);

        // Reset during ACK drops the write; requester 0 wins afterwards
        req = 4'b0010;
        tick();
        check("mid_rst_issue", 32'(fifo_data_in), 32'h1001);
        tick();
        rst = 1'b1;
        req = '0;
        tick();
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_wren", 32'(fifo_wr_en), 32'h0);
        check("mid_rst_busy", 32'(arb_busy), 32'h0);
        check("mid_rst_data", 32'(fifo_data_in), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'h0);
        req = 4'b1111;
        tick();
        check("post_rst_wren", 32'(fifo_wr_en), 32'h1);
        check("post_rst_data", 32'(fifo_data_in), 32'h1000);
        tick();
        tick();
        check("post_rst_gnt0", 32'(gnt), 32'h1);
        req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing the FIFO write port (2..8).
REQ-002 SHALL have parameter FIFO_WIDTH, default 16, meaning the data width of each requester and of the FIFO.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port: clk  input  1  clock; all logic on the rising edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: req  input  NUM_REQ  per-requester write request, held until that requester's gnt.
REQ-007 Port: req_data  input  NUM_REQ*FIFO_WIDTH  requester i data in bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 Port: gnt  output  NUM_REQ  one-hot, one-cycle pulse marking a completed write for that requester.
REQ-009 Port: fifo_wr_en  output  1  FIFO write enable.
REQ-010 Port: fifo_data_in  output  FIFO_WIDTH  FIFO write data.
REQ-011 Port: fifo_full  input  1  FIFO full flag.
REQ-012 Port: fifo_wr_ack  input  1  FIFO write acknowledge, registered by the FIFO and valid the cycle after fifo_wr_en.
REQ-013 Port: fifo_overflow  input  1  FIFO overflow flag, same timing as fifo_wr_ack.
REQ-014 Port: arb_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, ACK and DONE; all outputs SHALL be registered and Moore-decoded.
REQ-016 IDLE: if any req bit is set and fifo_full=0, the arbiter SHALL latch the round-robin winner index and its req_data, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 The round-robin search SHALL start at pointer ptr and wrap modulo NUM_REQ; the lowest index at or after ptr wins.
REQ-018 ISSUE: fifo_wr_en SHALL be 1 and fifo_data_in SHALL equal the latched data for exactly one cycle; the next state SHALL be ACK.
REQ-019 ACK: if fifo_wr_ack=1, the next state SHALL be DONE; otherwise (overflow or no ack), the next state SHALL be IDLE with ptr unchanged, so the write is retried.
REQ-020 DONE: gnt[winner] SHALL be 1 for one cycle, ptr SHALL become (winner+1) mod NUM_REQ, and the next state SHALL be IDLE.
REQ-021 Latency SHALL be as follows: with req sampled in IDLE at cycle N, fifo_wr_en is high at N+1 and gnt at N+3; at most one write occurs per 4 cycles.
REQ-022 fifo_wr_en SHALL be 0 in all states other than ISSUE, and fifo_data_in SHALL hold its last value outside ISSUE.
REQ-023 A req deasserted after latching SHALL NOT abort the transaction; gnt SHALL still pulse on success.
REQ-024 Changes to req or req_data after latching SHALL NOT affect the data written.
REQ-025 fifo_full rising while the FSM is in ISSUE or ACK SHALL NOT alter the sequence; the resulting fifo_overflow SHALL trigger a retry via ACK.
REQ-026 gnt SHALL never have more than one bit set.

Reset
REQ-027 On rst=1 at a rising edge, the block SHALL set state=IDLE, ptr=0, gnt=0, fifo_wr_en=0, fifo_data_in=0 and arb_busy=0, regardless of the current state.
REQ-028 Reset mid-transaction SHALL drop the transaction with no gnt.

Configuration
REQ-029 Macro FIFO_WR_ARB_RETRY_CNT_EN SHALL control the optional retry counter.
REQ-030 With the macro defined, the block SHALL add output port retry_cnt (8 bits), which counts ACK-to-IDLE retries, saturates at 255 and clears on reset.
REQ-031 Without the macro, the retry_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Single requester: req=4'b0010, data 16'hA5A5, FIFO empty -> fifo_wr_en at N+1 with 16'hA5A5; gnt=4'b0010 at N+3.
REQ-033 All requesters held high, FIFO never full -> grants occur in order 0,1,2,3,0, each 4 cycles apart.
REQ-034 fifo_full=1 with req=4'b0001 -> fifo_wr_en stays 0 and arb_busy stays 0; after full drops, a write is issued the next cycle.
REQ-035 ACK cycle with fifo_overflow=1 and fifo_wr_ack=0 -> no gnt, the same requester is reissued, and retry_cnt=1 when the macro is enabled.
REQ-036 rst=1 asserted during ACK -> next cycle state is IDLE, gnt=0, fifo_wr_en=0 and ptr=0, and requester 0 wins next.
REQ-037 req=4'b1001 with ptr=1 -> requester 3 wins before requester 0.
